// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: opcode/funct3 codes, pc_sel encodings and FSM state constants for the PC sequencer
package pc_ctrl_pkg;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [1:0] SEL_PC4   = 2'd0;
  localparam logic [1:0] SEL_ALU   = 2'd1;
  localparam logic [1:0] SEL_RESET = 2'd2;
  typedef logic [1:0] state_t;
  localparam state_t BOOT  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t FLUSH = 2'd2;
endpackage

// File: rtl/br_resolve.sv
// br_resolve: combinational control-transfer decision for the instruction in execute
module br_resolve
  import pc_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  input  logic        inst_valid,
  input  logic        BrEq,
  input  logic        BrLt,
  output logic        taken,
  output logic        is_branch,
  output logic        BrUn
);
  logic [6:0] op;
  logic [2:0] f3;
  logic       br_op;
  logic       cond;
  always_comb begin
    op    = inst[6:0];
    f3    = inst[14:12];
    br_op = op == OP_BRANCH;
    cond  = (f3 == F3_BEQ) ? BrEq :
            (f3 == F3_BNE) ? !BrEq :
            (f3 == F3_BLT || f3 == F3_BLTU) ? BrLt :
            (f3 == F3_BGE || f3 == F3_BGEU) ? !BrLt : 1'b0;
    BrUn      = br_op & inst[13];
    is_branch = inst_valid & br_op;
    taken     = inst_valid & (op == OP_JAL || op == OP_JALR || (br_op & cond));
  end
endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: PC select/write/flush sequencer with branch and redirect statistics
module pc_seq_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             inst_valid,
  input  logic             BrEq,
  input  logic             BrLt,
  input  logic             stall,
  output logic             BrUn,
  output logic [1:0]       pc_sel,
  output logic             pc_we,
  output logic             flush,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);
  state_t state, nxt;
  logic taken, is_branch, boot, run_go, redirect;
  br_resolve u_br (
    .inst(inst),
    .inst_valid(inst_valid),
    .BrEq(BrEq),
    .BrLt(BrLt),
    .taken(taken),
    .is_branch(is_branch),
    .BrUn(BrUn)
  );
  // unused encoding behaves as BOOT so the FSM self-recovers
  always_comb begin
    boot     = !(state == RUN || state == FLUSH);
    run_go   = state == RUN && !stall;
    redirect = run_go && taken;
    pc_sel   = boot ? SEL_RESET : redirect ? SEL_ALU : SEL_PC4;
    pc_we    = boot ? !rst : !stall;
    flush    = boot || state == FLUSH || redirect;
    nxt      = boot ? RUN : (state == FLUSH) ? (stall ? FLUSH : RUN) : redirect ? FLUSH : RUN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else begin
      state <= nxt;
      if (run_go && is_branch) br_cnt <= br_cnt + 1'b1;
      if (redirect) taken_cnt <= taken_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed self-checking bench for pc_seq_ctrl built with 4-bit counters
module tb_pc_seq_ctrl;
  logic        clk = 0;
  logic        rst = 0;
  logic [31:0] inst = 0;
  logic        inst_valid = 0, BrEq = 0, BrLt = 0, stall = 0;
  logic        BrUn, pc_we, flush;
  logic [1:0]  pc_sel;
  logic [3:0]  br_cnt, taken_cnt;
  logic [3:0]  exp_br = 0, exp_tk = 0;
  int n_cmp = 0, n_err = 0;

  pc_seq_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .BrEq(BrEq), .BrLt(BrLt),
    .stall(stall), .BrUn(BrUn), .pc_sel(pc_sel), .pc_we(pc_we), .flush(flush),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] i, input logic v, input logic eq, input logic lt, input logic s);
    inst = i; inst_valid = v; BrEq = eq; BrLt = lt; stall = s;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    set_in(32'h000003ef, 1, 1, 1, 1);
    tick();
    n_cmp++; if ({pc_sel, pc_we, flush} !== 4'b1001) begin n_err++; $display("FAIL rst_outs got %b want 1001", {pc_sel, pc_we, flush}); end
    tick();
    n_cmp++; if ({br_cnt, taken_cnt} !== 8'h00) begin n_err++; $display("FAIL rst_cnt got %h want 00", {br_cnt, taken_cnt}); end
    rst = 0;
    #1;
    n_cmp++; if ({pc_sel, pc_we, flush} !== 4'b1011) begin n_err++; $display("FAIL boot_outs got %b want 1011", {pc_sel, pc_we, flush}); end
    tick();
    set_in(32'h0, 0, 0, 0, 0);
    n_cmp++; if ({pc_sel, pc_we, flush, br_cnt, taken_cnt} !== 12'b0010_0000_0000) begin n_err++; $display("FAIL run_idle got %b want 001000000000", {pc_sel, pc_we, flush, br_cnt, taken_cnt}); end
    exp_br = 0; exp_tk = 0;
  endtask

  task automatic test_jal();
    set_in(32'h000003ef, 0, 0, 0, 0);
    n_cmp++; if ({pc_sel, flush} !== 3'b000) begin n_err++; $display("FAIL jal_invalid got %b want 000", {pc_sel, flush}); end
    set_in(32'h000003ef, 1, 0, 0, 0);
    n_cmp++; if ({pc_sel, pc_we, flush} !== 4'b0111) begin n_err++; $display("FAIL jal_taken got %b want 0111", {pc_sel, pc_we, flush}); end
    tick(); exp_tk++;
    n_cmp++; if ({pc_sel, pc_we, flush} !== 4'b0011) begin n_err++; $display("FAIL jal_flush got %b want 0011", {pc_sel, pc_we, flush}); end
    n_cmp++; if ({br_cnt, taken_cnt} !== {exp_br, exp_tk}) begin n_err++; $display("FAIL jal_cnt got %h want %h", {br_cnt, taken_cnt}, {exp_br, exp_tk}); end
    tick();
  endtask

  task automatic test_beq();
    set_in(32'h08248663, 1, 1, 0, 0);
    n_cmp++; if ({pc_sel, flush, BrUn} !== 4'b0110) begin n_err++; $display("FAIL beq_taken got %b want 0110", {pc_sel, flush, BrUn}); end
    tick(); exp_br++; exp_tk++;
    set_in(32'h08248663, 1, 1, 0, 0);
    n_cmp++; if ({pc_sel, flush} !== 3'b001) begin n_err++; $display("FAIL beq_flush_ignores got %b want 001", {pc_sel, flush}); end
    tick();
    n_cmp++; if ({br_cnt, taken_cnt} !== {exp_br, exp_tk}) begin n_err++; $display("FAIL beq_cnt got %h want %h", {br_cnt, taken_cnt}, {exp_br, exp_tk}); end
    set_in(32'h08248663, 1, 0, 1, 0);
    n_cmp++; if ({pc_sel, pc_we, flush} !== 4'b0010) begin n_err++; $display("FAIL beq_nt got %b want 0010", {pc_sel, pc_we, flush}); end
    tick(); exp_br++;
    n_cmp++; if ({br_cnt, taken_cnt} !== {exp_br, exp_tk}) begin n_err++; $display("FAIL beq_nt_cnt got %h want %h", {br_cnt, taken_cnt}, {exp_br, exp_tk}); end
  endtask

  task automatic test_bltu();
    set_in(32'h0666ee63, 1, 0, 1, 0);
    n_cmp++; if ({pc_sel, flush, BrUn} !== 4'b0111) begin n_err++; $display("FAIL bltu got %b want 0111", {pc_sel, flush, BrUn}); end
    tick(); exp_br++; exp_tk++;
    tick();
    set_in(32'h06777c63, 1, 0, 1, 0);
    n_cmp++; if ({pc_sel, flush, BrUn} !== 4'b0001) begin n_err++; $display("FAIL bgeu got %b want 0001", {pc_sel, flush, BrUn}); end
    tick(); exp_br++;
    set_in(32'h00002063, 1, 1, 1, 0);
    n_cmp++; if ({pc_sel, flush} !== 3'b000) begin n_err++; $display("FAIL f3_010 got %b want 000", {pc_sel, flush}); end
    tick(); exp_br++;
    n_cmp++; if ({br_cnt, taken_cnt} !== {exp_br, exp_tk}) begin n_err++; $display("FAIL bltu_cnt got %h want %h", {br_cnt, taken_cnt}, {exp_br, exp_tk}); end
  endtask

  task automatic test_stall();
    set_in(32'h08351463, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if ({pc_sel, pc_we, flush, br_cnt, taken_cnt} !== {4'b0000, exp_br, exp_tk}) begin n_err++; $display("FAIL stall_run%0d got %h want %h", k, {pc_sel, pc_we, flush, br_cnt, taken_cnt}, {4'b0000, exp_br, exp_tk}); end
      tick();
    end
    set_in(32'h08351463, 1, 0, 0, 0);
    n_cmp++; if ({pc_sel, pc_we, flush} !== 4'b0111) begin n_err++; $display("FAIL stall_release got %b want 0111", {pc_sel, pc_we, flush}); end
    tick(); exp_br++; exp_tk++;
    set_in(32'h0, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if ({pc_sel, pc_we, flush} !== 4'b0001) begin n_err++; $display("FAIL stall_flush%0d got %b want 0001", k, {pc_sel, pc_we, flush}); end
      tick();
    end
    set_in(32'h0, 0, 0, 0, 0);
    n_cmp++; if ({pc_sel, pc_we, flush} !== 4'b0011) begin n_err++; $display("FAIL flush_exit got %b want 0011", {pc_sel, pc_we, flush}); end
    tick();
    n_cmp++; if ({pc_sel, pc_we, flush, br_cnt, taken_cnt} !== {4'b0010, exp_br, exp_tk}) begin n_err++; $display("FAIL stall_after got %h want %h", {pc_sel, pc_we, flush, br_cnt, taken_cnt}, {4'b0010, exp_br, exp_tk}); end
  endtask

  task automatic test_nonctrl();
    set_in(32'h00840783, 1, 1, 1, 0);
    n_cmp++; if ({pc_sel, flush, BrUn} !== 4'b0000) begin n_err++; $display("FAIL lb got %b want 0000", {pc_sel, flush, BrUn}); end
    tick();
    set_in(32'h00840783, 1, 0, 0, 0);
    tick();
    n_cmp++; if ({br_cnt, taken_cnt} !== {exp_br, exp_tk}) begin n_err++; $display("FAIL lb_cnt got %h want %h", {br_cnt, taken_cnt}, {exp_br, exp_tk}); end
  endtask

  task automatic test_midreset_wrap();
    set_in(32'h000003ef, 1, 0, 0, 0);
    tick();
    set_in(32'h0, 0, 0, 0, 1);
    rst = 1;
    #1;
    n_cmp++; if ({pc_sel, pc_we, flush, br_cnt, taken_cnt} !== 12'b1001_0000_0000) begin n_err++; $display("FAIL midreset got %b want 100100000000", {pc_sel, pc_we, flush, br_cnt, taken_cnt}); end
    tick();
    rst = 0;
    tick();
    for (int k = 1; k <= 16; k++) begin
      set_in(32'h000003ef, 1, 0, 0, 0);
      tick();
      set_in(32'h0, 0, 0, 0, 0);
      tick();
      if (k == 15) begin
        n_cmp++; if (taken_cnt !== 4'd15) begin n_err++; $display("FAIL wrap_15 got %0d want 15", taken_cnt); end
      end
    end
    n_cmp++; if ({br_cnt, taken_cnt} !== 8'h00) begin n_err++; $display("FAIL wrap_16 got %h want 00", {br_cnt, taken_cnt}); end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_beq();
    test_bltu();
    test_stall();
    test_nonctrl();
    test_midreset_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
